// File: rtl/sensor_scan_ctrl.sv
// sensor_scan_ctrl: sequences an 8:1 sensor mux, captures each channel after a settle
// time, presents samples over valid/ready and keeps sticky per-channel alarms.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_enable          run continuous scanning
//   i_mux_out         data from the sensor mux
//   o_address         channel select to the mux
//   o_sample_data     captured sample
//   o_sample_chan     channel of o_sample_data
//   o_sample_valid    sample valid
//   i_sample_ready    downstream accepts sample
//   i_threshold       unsigned alarm threshold
//   i_alarm_clr       clears all alarm bits
//   o_alarm           sticky alarm, bit i = channel i
//   o_scan_done       1-cycle pulse after the channel 7 handshake
//   o_busy            state != IDLE
module sensor_scan_ctrl #(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_mux_out,
  output logic [2:0]        o_address,
  output logic [DATA_W-1:0] o_sample_data,
  output logic [2:0]        o_sample_chan,
  output logic              o_sample_valid,
  input  logic              i_sample_ready,
  input  logic [DATA_W-1:0] i_threshold,
  input  logic              i_alarm_clr,
  output logic [7:0]        o_alarm,
  output logic              o_scan_done,
  output logic              o_busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [2:0]        r_address;
  logic [DATA_W-1:0] r_sample_data;
  logic [2:0]        r_sample_chan;
  logic              r_sample_valid;
  logic [7:0]        r_alarm;
  logic              r_scan_done;
  logic              r_busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_address      <= '0;
      r_sample_data  <= '0;
      r_sample_chan  <= '0;
      r_sample_valid <= 1'b0;
      r_alarm        <= '0;
      r_scan_done    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_scan_done <= 1'b0;
      // The per-bit set below is a later assignment, so it wins over this clear.
      if (i_alarm_clr) r_alarm <= '0;
      case (r_state)
        IDLE: begin
          r_address <= '0;
          if (i_enable) begin
            r_state <= SETTLE;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SETTLE: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'(SETTLE_CYCLES - 1)) begin
            r_sample_data  <= i_mux_out;
            r_sample_chan  <= r_address;
            r_sample_valid <= 1'b1;
            r_state        <= PRESENT;
            if (i_mux_out > i_threshold) r_alarm[r_address] <= 1'b1;
          end
        end
        PRESENT: begin
          if (i_sample_ready) begin
            r_sample_valid <= 1'b0;
            r_scan_done    <= (r_address == 3'd7);
            // Stopping forces the next sweep to start from channel 0.
            if (i_enable) begin
              r_state   <= SETTLE;
              r_cnt     <= '0;
              r_address <= r_address + 3'd1;
            end else begin
              r_state   <= IDLE;
              r_address <= '0;
              r_busy    <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign o_address      = r_address;
  assign o_sample_data  = r_sample_data;
  assign o_sample_chan  = r_sample_chan;
  assign o_sample_valid = r_sample_valid;
  assign o_alarm        = r_alarm;
  assign o_scan_done    = r_scan_done;
  assign o_busy         = r_busy;
endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// tb_sensor_scan_ctrl: directed self-checking bench for sensor_scan_ctrl.
module tb_sensor_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_enable = 1'b0;
  logic [7:0] i_mux_out;
  logic [2:0] o_address;
  logic [7:0] o_sample_data;
  logic [2:0] o_sample_chan;
  logic       o_sample_valid;
  logic       i_sample_ready = 1'b1;
  logic [7:0] i_threshold = 8'hff;
  logic       i_alarm_clr = 1'b0;
  logic [7:0] o_alarm;
  logic       o_scan_done;
  logic       o_busy;
  logic [7:0] chan_val [8];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign i_mux_out = chan_val[o_address];
  sensor_scan_ctrl #(.DATA_W(8), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_mux_out(i_mux_out),
    .o_address(o_address), .o_sample_data(o_sample_data), .o_sample_chan(o_sample_chan),
    .o_sample_valid(o_sample_valid), .i_sample_ready(i_sample_ready),
    .i_threshold(i_threshold), .i_alarm_clr(i_alarm_clr), .o_alarm(o_alarm),
    .o_scan_done(o_scan_done), .o_busy(o_busy)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid();
    int n = 0;
    do begin
      step();
      n++;
    end while (!o_sample_valid && n < 20);
    if (!o_sample_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask
  task automatic wait_chan(input logic [2:0] c);
    int n = 0;
    do begin
      wait_valid();
      n++;
    end while (o_sample_chan != c && n < 10);
    chk("sync_chan", 32'(o_sample_chan), 32'(c));
  endtask
  initial begin
    for (int i = 0; i < 8; i++) chan_val[i] = 8'h10 + 8'(i);
    #1;
    chk("rst_valid", 32'(o_sample_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_addr", 32'(o_address), 32'd0);
    // full sweep with ready tied high
    i_enable = 1'b1;
    step();
    chk("en_busy", 32'(o_busy), 32'd1);
    chk("en_valid0", 32'(o_sample_valid), 32'd0);
    step();
    chk("en_valid1", 32'(o_sample_valid), 32'd0);
    step();
    chk("first_valid", 32'(o_sample_valid), 32'd1);
    chk("first_data", 32'(o_sample_data), 32'h10);
    chk("first_chan", 32'(o_sample_chan), 32'd0);
    for (int c = 1; c < 8; c++) begin
      step();
      chk("hs_valid", 32'(o_sample_valid), 32'd0);
      chk("hs_addr", 32'(o_address), 32'(c));
      chk("hs_done", 32'(o_scan_done), 32'd0);
      step();
      chk("settle_valid", 32'(o_sample_valid), 32'd0);
      step();
      chk("sweep_valid", 32'(o_sample_valid), 32'd1);
      chk("sweep_data", 32'(o_sample_data), 32'h10 + 32'(c));
      chk("sweep_chan", 32'(o_sample_chan), 32'(c));
    end
    step();
    chk("done_pulse", 32'(o_scan_done), 32'd1);
    chk("wrap_addr", 32'(o_address), 32'd0);
    step();
    chk("done_drop", 32'(o_scan_done), 32'd0);
    // backpressure on channel 3
    wait_chan(3'd3);
    i_sample_ready = 1'b0;
    chan_val[3] = 8'h99;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", 32'(o_sample_valid), 32'd1);
      chk("bp_data", 32'(o_sample_data), 32'h13);
      chk("bp_chan", 32'(o_sample_chan), 32'd3);
      chk("bp_addr", 32'(o_address), 32'd3);
    end
    i_sample_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(o_sample_valid), 32'd0);
    chk("bp_release_addr", 32'(o_address), 32'd4);
    chan_val[3] = 8'h13;
    wait_valid();
    chk("bp_next_chan", 32'(o_sample_chan), 32'd4);
    chk("bp_next_data", 32'(o_sample_data), 32'h14);
    chk("alarm_none", 32'(o_alarm), 32'd0);
    // alarm: ch5 above threshold, ch6 equal
    i_threshold = 8'h80;
    chan_val[5] = 8'h81;
    chan_val[6] = 8'h80;
    wait_chan(3'd7);
    chk("alarm_set", 32'(o_alarm), 32'h20);
    chan_val[5] = 8'h00;
    wait_chan(3'd7);
    chk("alarm_sticky", 32'(o_alarm), 32'h20);
    i_alarm_clr = 1'b1;
    step();
    i_alarm_clr = 1'b0;
    chk("alarm_clr", 32'(o_alarm), 32'd0);
    // clear/set collision on the ch2 capture edge
    chan_val[0] = 8'h90;
    wait_chan(3'd0);
    chk("alarm_ch0", 32'(o_alarm), 32'h01);
    chan_val[0] = 8'h10;
    chan_val[2] = 8'ha0;
    wait_chan(3'd1);
    step();
    step();
    i_alarm_clr = 1'b1;
    step();
    i_alarm_clr = 1'b0;
    chk("coll_valid", 32'(o_sample_valid), 32'd1);
    chk("coll_chan", 32'(o_sample_chan), 32'd2);
    chk("coll_alarm", 32'(o_alarm), 32'h04);
    chan_val[2] = 8'h12;
    // enable dropped during ch4 settle
    wait_chan(3'd3);
    step();
    chk("drop_addr", 32'(o_address), 32'd4);
    i_enable = 1'b0;
    step();
    step();
    chk("drop_valid", 32'(o_sample_valid), 32'd1);
    chk("drop_chan", 32'(o_sample_chan), 32'd4);
    chk("drop_data", 32'(o_sample_data), 32'h14);
    chk("drop_busy", 32'(o_busy), 32'd1);
    step();
    chk("stop_valid", 32'(o_sample_valid), 32'd0);
    chk("stop_addr", 32'(o_address), 32'd0);
    chk("stop_busy", 32'(o_busy), 32'd0);
    chk("stop_done", 32'(o_scan_done), 32'd0);
    repeat (3) step();
    chk("idle_hold_busy", 32'(o_busy), 32'd0);
    chk("idle_hold_valid", 32'(o_sample_valid), 32'd0);
    chan_val[0] = 8'h90;
    i_enable = 1'b1;
    wait_valid();
    chk("restart_chan", 32'(o_sample_chan), 32'd0);
    chk("restart_data", 32'(o_sample_data), 32'h90);
    chk("restart_alarm", 32'(o_alarm), 32'h05);
    // async reset while presenting
    i_sample_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(o_sample_valid), 32'd0);
    chk("arst_data", 32'(o_sample_data), 32'd0);
    chk("arst_chan", 32'(o_sample_chan), 32'd0);
    chk("arst_addr", 32'(o_address), 32'd0);
    chk("arst_alarm", 32'(o_alarm), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_done", 32'(o_scan_done), 32'd0);
    step();
    chk("arst_hold_busy", 32'(o_busy), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
